// File: rtl/life_pkg.sv
// Shared constants and types for the Game-of-Life generation stepper.
package life_pkg;
  localparam int GRID_W_DEF = 40;
  localparam int GRID_H_DEF = 30;
  localparam int XW         = 6;
  localparam int YW         = 5;
  localparam int PARK_X     = 0;
  localparam int PARK_Y     = GRID_H_DEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_EVAL,
    ST_FLUSH,
    ST_DONE
  } state_t;

  // One window column: bit0 = row y-1, bit1 = row y, bit2 = row y+1.
  typedef logic [2:0] col_t;
endpackage

// File: rtl/life_rule.sv
// B3/S23 cell rule over a 3x3 window given as left/mid/right columns.
module life_rule
  import life_pkg::*;
(
  input  col_t i_left,
  input  col_t i_mid,
  input  col_t i_right,
  output logic o_alive
);
  logic [3:0] w_n;

  always_comb begin
    w_n = 4'(i_left[0]) + 4'(i_left[1]) + 4'(i_left[2]) +
          4'(i_mid[0])  + 4'(i_mid[2]) +
          4'(i_right[0]) + 4'(i_right[1]) + 4'(i_right[2]);
    o_alive = (w_n == 4'd3) | (i_mid[1] & (w_n == 4'd2));
  end
endmodule

// File: rtl/life_step_ctrl.sv
// Computes one Life generation in place: streams rows through a 3x3 window
// and writes each row back one row late so no neighbour is overwritten early.
module life_step_ctrl
  import life_pkg::*;
#(
  parameter int GRID_W = GRID_W_DEF,
  parameter int GRID_H = GRID_H_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step_req,
  input  logic          run,
  input  logic          draw_busy,
  output logic [XW-1:0] ctrl_x_chunk,
  output logic [YW-1:0] ctrl_y_chunk,
  input  logic [1:0]    ctrl_in,
  output logic [XW-1:0] write_x_chunk,
  output logic [YW-1:0] write_y_chunk,
  output logic [1:0]    data_out,
  output logic          wr_en,
  output logic          busy,
  output logic          step_done
);
  localparam logic [XW-1:0] X_END  = XW'(GRID_W);
  localparam logic [XW-1:0] X_LAST = XW'(GRID_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(GRID_H - 1);
  localparam logic [YW:0]   RD_MAX = (YW+1)'(GRID_H);
  localparam logic [XW-1:0] PX     = XW'(PARK_X);
  localparam logic [YW-1:0] PY     = YW'(GRID_H);

  state_t              r_state, w_next;
  logic [XW-1:0]       r_x;
  logic [1:0]          r_r;
  logic [YW-1:0]       r_y, r_wy;
  col_t                r_col, r_mid, r_right, w_new_col;
  logic [GRID_W-1:0]   r_next_row, r_pending, w_next_full;
  logic                w_rule;
  logic [YW:0]         w_rd_sum;
  logic                w_rd_valid;
  logic [YW-1:0]       w_rd_row;
  logic                w_ctrl_unused;

  assign w_ctrl_unused = ctrl_in[1];

  always_comb begin
    w_rd_sum   = {1'b0, r_y} + {{(YW-1){1'b0}}, r_r};
    w_rd_valid = (w_rd_sum != '0) && (w_rd_sum <= RD_MAX);
    w_rd_row   = YW'(w_rd_sum - (YW+1)'(1));
    w_new_col  = (r_x == X_END) ? '0 : r_col;
  end

  // Only the two newest columns are stored; after the shift the left column
  // is the old middle, so the rule sees the shifted window directly.
  life_rule u_rule (
    .i_left (r_mid),
    .i_mid  (r_right),
    .i_right(w_new_col),
    .o_alive(w_rule)
  );

  always_comb begin
    w_next_full             = r_next_row;
    w_next_full[GRID_W-1]   = w_rule;
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if ((step_req | run) & ~draw_busy) w_next = ST_READ;
      ST_READ:  if (r_r == 2'd2) w_next = ST_EVAL;
      ST_EVAL: begin
        if (r_x == X_END)       w_next = (r_y == '0) ? ST_READ : ST_FLUSH;
        else if (r_x == X_LAST) w_next = ST_EVAL;
        else                    w_next = ST_READ;
      end
      ST_FLUSH: begin
        if (r_x == X_LAST) begin
          if (r_y != Y_LAST)      w_next = ST_READ;
          else if (r_wy == Y_LAST) w_next = ST_DONE;
          else                    w_next = ST_FLUSH;
        end
      end
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy          = 1'b0;
    step_done     = 1'b0;
    wr_en         = 1'b0;
    data_out      = '0;
    write_x_chunk = PX;
    write_y_chunk = PY;
    ctrl_x_chunk  = PX;
    ctrl_y_chunk  = PY;
    case (r_state)
      ST_READ: begin
        busy = 1'b1;
        if (w_rd_valid) begin
          ctrl_x_chunk = r_x;
          ctrl_y_chunk = w_rd_row;
        end
      end
      ST_EVAL:  busy = 1'b1;
      ST_FLUSH: begin
        busy          = 1'b1;
        wr_en         = 1'b1;
        write_x_chunk = r_x;
        write_y_chunk = r_wy;
        data_out      = {r_pending[r_x], 1'b0};
      end
      ST_DONE:  step_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_x        <= '0;
      r_r        <= '0;
      r_y        <= '0;
      r_wy       <= '0;
      r_col      <= '0;
      r_mid      <= '0;
      r_right    <= '0;
      r_next_row <= '0;
      r_pending  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_x     <= '0;
          r_r     <= '0;
          r_y     <= '0;
          r_wy    <= '0;
          r_mid   <= '0;
          r_right <= '0;
        end
        ST_READ: begin
          r_col[r_r] <= w_rd_valid & ctrl_in[0];
          r_r        <= (r_r == 2'd2) ? 2'd0 : r_r + 2'd1;
        end
        ST_EVAL: begin
          r_mid   <= r_right;
          r_right <= w_new_col;
          if (r_x != '0) r_next_row[r_x - XW'(1)] <= w_rule;
          if (r_x == X_END) begin
            r_x <= '0;
            if (r_y == '0) begin
              r_pending <= w_next_full;
              r_y       <= r_y + YW'(1);
            end else begin
              r_wy <= r_y - YW'(1);
            end
          end else begin
            r_x <= r_x + XW'(1);
          end
        end
        ST_FLUSH: begin
          if (r_x == X_LAST) begin
            r_x       <= '0;
            r_pending <= r_next_row;
            // Last row: flush row H-2, then re-enter FLUSH for row H-1.
            if (r_y == Y_LAST) r_wy <= Y_LAST;
            else               r_y  <= r_y + YW'(1);
          end else begin
            r_x <= r_x + XW'(1);
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_life_step_ctrl.sv
// Bench for life_step_ctrl: behavioural grid memory, reference Life model and
// an in-order write scoreboard.
module tb_life_step_ctrl;
  localparam int GW       = 40;
  localparam int GH       = 30;
  localparam int STEP_CYC = GH * (GW * 4 + 1) + GH * GW;

  typedef logic [GH-1:0][GW-1:0] grid_t;

  logic       clk, reset, step_req, run, draw_busy;
  logic [5:0] ctrl_x_chunk, write_x_chunk;
  logic [4:0] ctrl_y_chunk, write_y_chunk;
  logic [1:0] ctrl_in, data_out;
  logic       wr_en, busy, step_done;

  grid_t       g_mem;
  logic [12:0] sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          busy_cnt = 0;
  int          wr_cnt = 0;

  life_step_ctrl #(.GRID_W(GW), .GRID_H(GH)) dut (
    .clk          (clk),
    .reset        (reset),
    .step_req     (step_req),
    .run          (run),
    .draw_busy    (draw_busy),
    .ctrl_x_chunk (ctrl_x_chunk),
    .ctrl_y_chunk (ctrl_y_chunk),
    .ctrl_in      (ctrl_in),
    .write_x_chunk(write_x_chunk),
    .write_y_chunk(write_y_chunk),
    .data_out     (data_out),
    .wr_en        (wr_en),
    .busy         (busy),
    .step_done    (step_done)
  );

  assign ctrl_in = (32'(ctrl_y_chunk) < GH && 32'(ctrl_x_chunk) < GW) ?
                   {1'b0, g_mem[ctrl_y_chunk][ctrl_x_chunk]} : 2'b00;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic grid_t life_next(input grid_t g);
    grid_t n;
    int    cnt, yy, xx;
    n = '0;
    for (int y = 0; y < GH; y++) begin
      for (int x = 0; x < GW; x++) begin
        cnt = 0;
        for (int dy = -1; dy <= 1; dy++) begin
          for (int dx = -1; dx <= 1; dx++) begin
            yy = y + dy;
            xx = x + dx;
            if ((dy != 0 || dx != 0) && yy >= 0 && yy < GH && xx >= 0 && xx < GW)
              cnt += int'(g[yy][xx]);
          end
        end
        n[y][x] = (cnt == 3) || (g[y][x] && cnt == 2);
      end
    end
    return n;
  endfunction

  function automatic int pop_count(input grid_t g);
    int c = 0;
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++) c += int'(g[y][x]);
    return c;
  endfunction

  // Writes arrive row by row, top to bottom, each row left to right.
  task automatic push_exp(input grid_t n);
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++)
        sb.push_back({5'(y), 6'(x), n[y][x], 1'b0});
  endtask

  task automatic rand_grid();
    for (int y = 0; y < GH; y++)
      for (int x = 0; x < GW; x++) g_mem[y][x] = ($urandom_range(3) == 0);
  endtask

  task automatic wait_done(input bit poke);
    int k = 0;
    while (!step_done && k < STEP_CYC + 100) begin
      if (poke && k == 100) step_req = 1'b1;
      if (poke && k == 101) step_req = 1'b0;
      tick();
      k++;
    end
    chk("done_seen", 32'(step_done), 32'd1);
    chk("busy_cycles", 32'(busy_cnt), 32'(STEP_CYC));
    tick();
    chk("done_pulse", 32'(step_done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    tick();
    tick();
    chk("no_requeue", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic run_step(input bit poke);
    push_exp(life_next(g_mem));
    busy_cnt = 0;
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    wait_done(poke);
  endtask

  initial begin
    int    k, n, nw;
    int    t[4];
    bit    found;
    grid_t g;

    reset = 1'b0; step_req = 1'b0; run = 1'b0; draw_busy = 1'b0;
    g_mem = '0;
    tick();
    tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_en", 32'(wr_en), 32'd0);
    chk("rst_done", 32'(step_done), 32'd0);
    chk("rst_wr_addr", 32'({write_y_chunk, write_x_chunk}), 32'({5'd30, 6'd0}));
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_rd_addr", 32'({ctrl_y_chunk, ctrl_x_chunk}), 32'({5'd30, 6'd0}));
    reset = 1'b1;
    tick();

    fork
      forever begin
        @(posedge clk);
        if (wr_en === 1'b1 && 32'(write_y_chunk) < GH && 32'(write_x_chunk) < GW)
          g_mem[write_y_chunk][write_x_chunk] = data_out[1];
      end
      forever begin
        logic [12:0] e;
        @(negedge clk);
        if (busy) busy_cnt++;
        if (wr_en) begin
          wr_cnt++;
          if (sb.size() == 0) chk("wr_unexp", 32'(wr_en), 32'd0);
          else begin
            e = sb.pop_front();
            chk("wr", 32'({write_y_chunk, write_x_chunk, data_out}), 32'(e));
          end
        end else begin
          chk("park_wr", 32'({write_y_chunk, write_x_chunk, data_out}),
              32'({5'd30, 6'd0, 2'd0}));
        end
        if (!busy)
          chk("park_rd", 32'({ctrl_y_chunk, ctrl_x_chunk}), 32'({5'd30, 6'd0}));
      end
    join_none

    // Blinker, with a stray step_req mid-step that must not be queued.
    g_mem = '0;
    g_mem[5][10] = 1'b1; g_mem[5][11] = 1'b1; g_mem[5][12] = 1'b1;
    run_step(1'b1);
    chk("blk_11_4", 32'(g_mem[4][11]), 32'd1);
    chk("blk_11_5", 32'(g_mem[5][11]), 32'd1);
    chk("blk_11_6", 32'(g_mem[6][11]), 32'd1);
    chk("blk_pop", 32'(pop_count(g_mem)), 32'd3);

    // Corners: still-life block, lone corner cell dies, no wrap-around.
    g_mem = '0;
    g_mem[0][0] = 1'b1; g_mem[0][1] = 1'b1; g_mem[1][0] = 1'b1; g_mem[1][1] = 1'b1;
    g_mem[29][39] = 1'b1;
    run_step(1'b0);
    chk("edge_00", 32'(g_mem[0][0]), 32'd1);
    chk("edge_10", 32'(g_mem[0][1]), 32'd1);
    chk("edge_01", 32'(g_mem[1][0]), 32'd1);
    chk("edge_11", 32'(g_mem[1][1]), 32'd1);
    chk("edge_39_29", 32'(g_mem[29][39]), 32'd0);
    chk("edge_0_29", 32'(g_mem[29][0]), 32'd0);
    chk("edge_39_0", 32'(g_mem[0][39]), 32'd0);
    chk("edge_pop", 32'(pop_count(g_mem)), 32'd4);

    // Drawer interlock on a random grid; draw_busy rises again mid-step.
    rand_grid();
    draw_busy = 1'b1;
    step_req  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_idle", 32'(busy), 32'd0);
    end
    push_exp(life_next(g_mem));
    busy_cnt  = 0;
    draw_busy = 1'b0;
    tick();
    chk("ilk_start", 32'(busy), 32'd1);
    chk("ilk_rd0", 32'({ctrl_y_chunk, ctrl_x_chunk}), 32'({5'd30, 6'd0}));
    step_req  = 1'b0;
    draw_busy = 1'b1;
    tick();
    chk("ilk_rd1", 32'({ctrl_y_chunk, ctrl_x_chunk}), 32'({5'd0, 6'd0}));
    wait_done(1'b0);
    draw_busy = 1'b0;

    // Reset while flushing row 10.
    rand_grid();
    push_exp(life_next(g_mem));
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    found = 1'b0;
    k = 0;
    while (!found && k < STEP_CYC) begin
      if (wr_en && write_y_chunk == 5'd10 && write_x_chunk == 6'd5) found = 1'b1;
      else begin
        tick();
        k++;
      end
    end
    chk("flush10_seen", 32'(found), 32'd1);
    reset = 1'b0;
    tick();
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_wr_en", 32'(wr_en), 32'd0);
    chk("mid_done", 32'(step_done), 32'd0);
    chk("mid_wr_addr", 32'({write_y_chunk, write_x_chunk, data_out}), 32'({5'd30, 6'd0, 2'd0}));
    chk("mid_rd_addr", 32'({ctrl_y_chunk, ctrl_x_chunk}), 32'({5'd30, 6'd0}));
    nw = wr_cnt;
    tick();
    reset = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("mid_no_wr", 32'(wr_cnt), 32'(nw));
    chk("mid_idle", 32'(busy), 32'd0);
    sb.delete();

    // Free-running glider for four generations.
    g_mem = '0;
    g_mem[0][1] = 1'b1; g_mem[1][2] = 1'b1;
    g_mem[2][0] = 1'b1; g_mem[2][1] = 1'b1; g_mem[2][2] = 1'b1;
    g = g_mem;
    for (int i = 0; i < 4; i++) begin
      g = life_next(g);
      push_exp(g);
    end
    run = 1'b1;
    n = 0;
    k = 0;
    while (n < 4 && k < 4 * (STEP_CYC + 100)) begin
      tick();
      k++;
      if (step_done) begin
        t[n] = k;
        n++;
        if (n == 4) run = 1'b0;
      end
    end
    chk("run_gens", 32'(n), 32'd4);
    for (int i = 1; i < 4; i++)
      if (i < n) chk("run_period", 32'(t[i] - t[i-1]), 32'd6032);
    tick();
    tick();
    tick();
    chk("run_stop", 32'(busy), 32'd0);
    chk("run_sb", 32'(sb.size()), 32'd0);
    chk("gl_2_1", 32'(g_mem[1][2]), 32'd1);
    chk("gl_3_2", 32'(g_mem[2][3]), 32'd1);
    chk("gl_1_3", 32'(g_mem[3][1]), 32'd1);
    chk("gl_2_3", 32'(g_mem[3][2]), 32'd1);
    chk("gl_3_3", 32'(g_mem[3][3]), 32'd1);
    chk("gl_pop", 32'(pop_count(g_mem)), 32'd5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
